// File: rtl/tpg_multi_if.sv
// Video output bus of the test pattern generator: raster timing, pixel data,
// frame/line markers and the completed-frame counter.
interface tpg_multi_if #(
   parameter int unsigned PW      = 8,
   parameter int unsigned FC_BITS = 8
);
   localparam int unsigned RGB_W = 3 * PW;

   logic               hs;
   logic               vs;
   logic               vld;
   logic [RGB_W-1:0]   rgb;
   logic               sof;
   logic               eol;
   logic [FC_BITS-1:0] frame_cnt;

   modport master (
      output hs, vs, vld, rgb, sof, eol, frame_cnt
   );

   modport slave (
      input hs, vs, vld, rgb, sof, eol, frame_cnt
   );
endinterface

// File: rtl/tpg_multi.sv
// Multi-pattern video test pattern generator: programmable raster timing with
// ramp/hramp/bars/checker/solid patterns. Optional overlay: TPG_CROSSHAIR_EN.
module tpg_multi #(
   parameter int unsigned PW        = 8,
   parameter int unsigned H_BITS    = 12,
   parameter int unsigned V_BITS    = 12,
   parameter int unsigned BAR_SHIFT = 5,
   parameter int unsigned CK_SHIFT  = 3,
   parameter int unsigned FC_BITS   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [2:0]          mode,
   input  logic [3*PW-1:0]     solid_rgb,
   input  logic [H_BITS-1:0]   tHS_START,
   input  logic [H_BITS-1:0]   tHS_END,
   input  logic [H_BITS-1:0]   tHACT_START,
   input  logic [H_BITS-1:0]   tHACT_END,
   input  logic [H_BITS-1:0]   tH_END,
   input  logic [V_BITS-1:0]   tVS_START,
   input  logic [V_BITS-1:0]   tVS_END,
   input  logic [V_BITS-1:0]   tVACT_START,
   input  logic [V_BITS-1:0]   tVACT_END,
   input  logic [V_BITS-1:0]   tV_END,
`ifdef TPG_CROSSHAIR_EN
   input  logic [H_BITS-1:0]   xh_x,
   input  logic [V_BITS-1:0]   xh_y,
`endif
   tpg_multi_if.master         vid
);

   localparam int unsigned RGB_W = 3 * PW;

   localparam logic [2:0] MODE_RAMP  = 3'd0;
   localparam logic [2:0] MODE_HRAMP = 3'd1;
   localparam logic [2:0] MODE_BARS  = 3'd2;
   localparam logic [2:0] MODE_CHECK = 3'd3;
   localparam logic [2:0] MODE_SOLID = 3'd4;

   // Raster position and frame-persistent state
   logic [H_BITS-1:0]  r_x;
   logic [V_BITS-1:0]  r_y;
   logic [2:0]         r_mode;
   logic [PW-1:0]      r_ramp;
   logic [FC_BITS-1:0] r_fc;

   // Registered outputs
   logic               r_hs;
   logic               r_vs;
   logic               r_vld;
   logic               r_sof;
   logic               r_eol;
   logic [RGB_W-1:0]   r_rgb;

   logic               w_origin;
   logic [2:0]         w_mode;
   logic               w_x_end;
   logic               w_y_end;
   logic               w_hs;
   logic               w_vs;
   logic               w_hact;
   logic               w_vact;
   logic               w_vld;
   logic               w_sof;
   logic               w_eol;
   logic [H_BITS-1:0]  w_x_act;
   logic [V_BITS-1:0]  w_y_act;
   logic [PW-1:0]      w_hramp;
   logic [2:0]         w_bar;
   logic               w_ck;
   logic [RGB_W-1:0]   w_pat;
   logic [RGB_W-1:0]   w_rgb;
   logic               w_unused_bits;

   // The first pixel of a frame already uses the newly sampled mode
   assign w_origin = (r_x == '0) && (r_y == '0);
   assign w_mode   = w_origin ? mode : r_mode;

   // Equality wrap: a lowered END lets the counter run to full scale and recover
   assign w_x_end = (r_x == tH_END - H_BITS'(1));
   assign w_y_end = (r_y == tV_END - V_BITS'(1));

   assign w_hs   = (r_x >= tHS_START)   && (r_x < tHS_END);
   assign w_vs   = (r_y >= tVS_START)   && (r_y < tVS_END);
   assign w_hact = (r_x >= tHACT_START) && (r_x < tHACT_END);
   assign w_vact = (r_y >= tVACT_START) && (r_y < tVACT_END);
   assign w_vld  = w_hact && w_vact;

   assign w_sof = w_vld && (r_x == tHACT_START) && (r_y == tVACT_START);
   assign w_eol = w_vld && (r_x == tHACT_END - H_BITS'(1));

   assign w_x_act = r_x - tHACT_START;
   assign w_y_act = r_y - tVACT_START;

   assign w_hramp = PW'(w_x_act) + PW'(r_fc);
   // Bar index inverted so bar 0 is white and bar 7 is black
   assign w_bar   = ~3'(w_x_act >> BAR_SHIFT);
   assign w_ck    = w_x_act[CK_SHIFT] ^ w_y_act[CK_SHIFT];

   always_comb begin
      w_pat = '0;
      case (w_mode)
         MODE_RAMP:  w_pat = {r_ramp, r_ramp, r_ramp};
         MODE_HRAMP: w_pat = {w_hramp, w_hramp, w_hramp};
         MODE_BARS:  w_pat = {{PW{w_bar[2]}}, {PW{w_bar[1]}}, {PW{w_bar[0]}}};
         MODE_CHECK: w_pat = {RGB_W{w_ck}};
         MODE_SOLID: w_pat = solid_rgb;
         default:    w_pat = '0;
      endcase
`ifdef TPG_CROSSHAIR_EN
      if ((w_x_act == xh_x) || (w_y_act == xh_y)) begin
         w_pat = {{PW{1'b1}}, {(2*PW){1'b0}}};
      end
`endif
   end

   assign w_rgb = w_vld ? w_pat : '0;

   // Only selected bits of the offsets and frame count feed the patterns
   assign w_unused_bits = ^{w_x_act, w_y_act, r_fc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x    <= '0;
         r_y    <= '0;
         r_mode <= '0;
         r_ramp <= '0;
         r_fc   <= '0;
         r_hs   <= 1'b0;
         r_vs   <= 1'b0;
         r_vld  <= 1'b0;
         r_sof  <= 1'b0;
         r_eol  <= 1'b0;
         r_rgb  <= '0;
      end else if (!enable) begin
         // Disabled: park at the origin, abort the frame, keep frame count and ramp
         r_x    <= '0;
         r_y    <= '0;
         r_hs   <= 1'b0;
         r_vs   <= 1'b0;
         r_vld  <= 1'b0;
         r_sof  <= 1'b0;
         r_eol  <= 1'b0;
         r_rgb  <= '0;
      end else begin
         r_hs  <= w_hs;
         r_vs  <= w_vs;
         r_vld <= w_vld;
         r_sof <= w_sof;
         r_eol <= w_eol;
         r_rgb <= w_rgb;

         if (w_origin) begin
            r_mode <= mode;
         end
         if (w_vld) begin
            r_ramp <= r_ramp + PW'(1);
         end

         if (w_x_end) begin
            r_x <= '0;
            if (w_y_end) begin
               r_y  <= '0;
               r_fc <= r_fc + FC_BITS'(1);
            end else begin
               r_y <= r_y + V_BITS'(1);
            end
         end else begin
            r_x <= r_x + H_BITS'(1);
         end
      end
   end

   assign vid.hs        = r_hs;
   assign vid.vs        = r_vs;
   assign vid.vld       = r_vld;
   assign vid.rgb       = r_rgb;
   assign vid.sof       = r_sof;
   assign vid.eol       = r_eol;
   assign vid.frame_cnt = r_fc;

endmodule
